// File: rtl/tone_pkg.sv
// Shared constants, burst FSM states and the half-period helper for the
// multi-channel tone generator.
package tone_pkg;

  localparam int unsigned CLK_HZ   = 125_000_000;
  localparam int unsigned HALF_392 = 159439;
  localparam int unsigned HALF_110 = 568182;

  typedef enum logic [1:0] {
    BURST_IDLE,
    BURST_BUSY,
    BURST_DONE
  } burst_state_e;

  // Rounded half-period in clock cycles for a tone of freq_hz.
  function automatic int unsigned half_of(input int unsigned freq_hz);
    return (CLK_HZ + freq_hz) / (2 * freq_hz);
  endfunction

endpackage

// File: rtl/tone_div.sv
// Half-period divider with a toggle flop; restart or a zero half-period
// forces the count to zero and the output low.
module tone_div
  import tone_pkg::*;
#(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] half,
  output logic             tone
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tone_d = tone_q;
    if (restart || half == '0) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q >= half - DIV_W'(1)) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave tone generator: programmable half-period table,
// lowest-index enable priority, one-shot timed bursts and glitch-free restart.
module tone_gen_multi
  import tone_pkg::*;
#(
  parameter  int N_TONES = 4,
  parameter  int DIV_W   = 20,
  parameter  int DUR_W   = 28,
  localparam int IDX_W   = (N_TONES > 1) ? $clog2(N_TONES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [DIV_W-1:0]   cfg_half,
  input  logic [N_TONES-1:0] en,
  input  logic               burst_start,
  input  logic [IDX_W-1:0]   burst_idx,
  input  logic [DUR_W-1:0]   burst_len,
  output logic               burst_busy,
  output logic               burst_done,
  output logic               active,
  output logic [IDX_W-1:0]   active_idx,
  output logic               tone_out
);

  function automatic logic [DIV_W-1:0] defaultHalf(input int i);
    return (i == 0) ? DIV_W'(HALF_392) : (i == 1) ? DIV_W'(HALF_110) : '0;
  endfunction

  logic [DIV_W-1:0] table_q [N_TONES];
  logic [DIV_W-1:0] table_d [N_TONES];
  burst_state_e     state_q, state_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] burstIdx_q, burstIdx_d;
  logic             selValid_q, selValid_d;
  logic [IDX_W-1:0] selIdx_q, selIdx_d;
  logic             active_q, active_d;
  logic [IDX_W-1:0] activeIdx_q, activeIdx_d;
  logic             busyNext, restart;
  logic [DIV_W-1:0] divHalf;

  always_comb begin
    for (int i = 0; i < N_TONES; i++) begin
      table_d[i] = table_q[i];
      if (cfg_we && cfg_idx == IDX_W'(i)) table_d[i] = cfg_half;
    end
  end

  // rem_q holds the busy cycles still to come after the current one.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    burstIdx_d = burstIdx_q;
    case (state_q)
      BURST_BUSY: begin
        if (rem_q == '0) state_d = BURST_DONE;
        else             rem_d   = rem_q - DUR_W'(1);
      end
      default: begin
        state_d = BURST_IDLE;
        if (burst_start) begin
          if (burst_len == '0) begin
            state_d = BURST_DONE;
          end else begin
            state_d    = BURST_BUSY;
            rem_d      = burst_len - DUR_W'(1);
            burstIdx_d = burst_idx;
          end
        end
      end
    endcase
  end

  assign busyNext = (state_d == BURST_BUSY);

  // Selection is resolved against next-cycle table and burst state so the
  // registered outputs line up with the edge that sampled the request.
  always_comb begin
    selValid_d = 1'b0;
    selIdx_d   = '0;
    if (busyNext) begin
      selValid_d = 1'b1;
      selIdx_d   = burstIdx_d;
    end else begin
      for (int i = N_TONES - 1; i >= 0; i--) begin
        if (en[i] && table_d[i] != '0) begin
          selValid_d = 1'b1;
          selIdx_d   = IDX_W'(i);
        end
      end
    end
    active_d    = selValid_d && (table_d[selIdx_d] != '0);
    activeIdx_d = active_d ? selIdx_d : '0;
    restart     = (selValid_d != selValid_q) || (selIdx_d != selIdx_q) ||
                  (busyNext != (state_q == BURST_BUSY)) ||
                  (cfg_we && selValid_d && cfg_idx == selIdx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TONES; i++) table_q[i] <= defaultHalf(i);
      state_q     <= BURST_IDLE;
      rem_q       <= '0;
      burstIdx_q  <= '0;
      selValid_q  <= 1'b0;
      selIdx_q    <= '0;
      active_q    <= 1'b0;
      activeIdx_q <= '0;
    end else begin
      for (int i = 0; i < N_TONES; i++) table_q[i] <= table_d[i];
      state_q     <= state_d;
      rem_q       <= rem_d;
      burstIdx_q  <= burstIdx_d;
      selValid_q  <= selValid_d;
      selIdx_q    <= selIdx_d;
      active_q    <= active_d;
      activeIdx_q <= activeIdx_d;
    end
  end

  assign divHalf = active_q ? table_q[selIdx_q] : '0;

  tone_div #(.DIV_W(DIV_W)) uDiv (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .half    (divHalf),
    .tone    (tone_out)
  );

  assign burst_busy = (state_q == BURST_BUSY);
  assign burst_done = (state_q == BURST_DONE);
  assign active     = active_q;
  assign active_idx = activeIdx_q;

endmodule

// File: tb/tb_tone_gen_multi.sv
// Self-checking bench for tone_gen_multi: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_tone_gen_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [19:0] cfg_half;
  logic [3:0]  en;
  logic        burst_start;
  logic [1:0]  burst_idx;
  logic [27:0] burst_len;
  logic        burst_busy, burst_done, active, tone_out;
  logic [1:0]  active_idx;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  tone_gen_multi #(.N_TONES(4), .DIV_W(20), .DUR_W(28)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_half    (cfg_half),
    .en          (en),
    .burst_start (burst_start),
    .burst_idx   (burst_idx),
    .burst_len   (burst_len),
    .burst_busy  (burst_busy),
    .burst_done  (burst_done),
    .active      (active),
    .active_idx  (active_idx),
    .tone_out    (tone_out)
  );

  always #4 clk = ~clk;

  // Model: src 0 = none, 1 = enable priority, 2 = burst. Tone phase is derived
  // from the number of edges since the last restart.
  int unsigned mTable [4];
  int unsigned nTable [4];
  int          mRem, mBurstIdx, mSrc, mIdx, nSrc, nIdx;
  longint      mAge;
  int unsigned h;
  bit          nDone, restartM;
  bit          eBusy, eDone, eActive, eTone;
  int          eIdx;

  always @(posedge clk) begin
    if (rst) begin
      mTable = '{159439, 568182, 0, 0};
      mRem = 0; mBurstIdx = 0; mSrc = 0; mIdx = 0; mAge = 0;
      eBusy = 0; eDone = 0; eActive = 0; eTone = 0; eIdx = 0;
    end else begin
      nTable = mTable;
      if (cfg_we) nTable[cfg_idx] = cfg_half;
      nDone = 0;
      if (mRem > 0) begin
        mRem--;
        if (mRem == 0) nDone = 1;
      end else if (burst_start) begin
        if (burst_len == 0) nDone = 1;
        else begin
          mRem = int'(burst_len);
          mBurstIdx = int'(burst_idx);
        end
      end
      nSrc = 0; nIdx = 0;
      if (mRem > 0) begin
        nSrc = 2; nIdx = mBurstIdx;
      end else begin
        for (int i = 3; i >= 0; i--)
          if (en[i] && nTable[i] != 0) begin nSrc = 1; nIdx = i; end
      end
      restartM = (nSrc != mSrc) || (nIdx != mIdx) ||
                 (cfg_we && nSrc != 0 && int'(cfg_idx) == nIdx);
      mAge   = restartM ? 0 : mAge + 1;
      mTable = nTable;
      mSrc   = nSrc;
      mIdx   = nIdx;
      h       = (nSrc != 0) ? nTable[nIdx] : 0;
      eBusy   = (mRem > 0);
      eDone   = nDone;
      eActive = (h != 0);
      eIdx    = eActive ? nIdx : 0;
      eTone   = eActive ? bit'((mAge / h) % 2) : 1'b0;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_busy", burst_busy, eBusy);
      checkOutput("model_done", burst_done, eDone);
      checkOutput("model_active", active, eActive);
      checkOutput("model_idx", active_idx, eIdx);
      checkOutput("model_tone", tone_out, eTone);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] idx, input logic [19:0] half,
                               input logic [3:0] enV, input logic bs, input logic [1:0] bIdx,
                               input logic [27:0] bLen);
    cfg_we = we; cfg_idx = idx; cfg_half = half; en = enV;
    burst_start = bs; burst_idx = bIdx; burst_len = bLen;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 20'd0, en, 1'b0, 2'd0, 28'd0);
  endtask

  logic [15:0] pat;
  int busyCount, doneAt, rises;
  logic prevTone;

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_half = 0; en = 0;
    burst_start = 0; burst_idx = 0; burst_len = 0;
    step(); step();
    checkEn = 1'b1;
    checkOutput("reset_tone", tone_out, 0);
    checkOutput("reset_active", active, 0);
    checkOutput("reset_busy", burst_busy, 0);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 4'b0001, 0, 0, 0);
    checkOutput("en0_active", active, 1);
    checkOutput("en0_idx", active_idx, 0);
    idle(30);
    checkOutput("en0_tone_low", tone_out, 0);

    applyStimulus(1, 2'd2, 20'd4, 4'b0110, 0, 0, 0);
    checkOutput("prio_idx", active_idx, 1);
    applyStimulus(1, 2'd1, 20'd3, 4'b0110, 0, 0, 0);
    for (int i = 0; i < 20 && tone_out !== 1'b1; i++) idle(1);
    checkOutput("wait_tone_high", tone_out, 1);
    applyStimulus(0, 0, 0, 4'b0100, 0, 0, 0);
    pat = 16'hF0F0;
    checkOutput("drop_idx", active_idx, 2);
    checkOutput("drop_tone0", tone_out, pat[0]);
    for (int k = 1; k < 16; k++) begin
      idle(1);
      checkOutput("ch2_pattern", tone_out, pat[k]);
    end

    applyStimulus(0, 0, 0, 4'b0001, 0, 0, 0);
    idle(3);
    prevTone = tone_out;
    applyStimulus(0, 0, 0, 4'b0001, 1, 2'd2, 28'd20);
    busyCount = 0; doneAt = 0; rises = 0;
    for (int off = 1; off <= 30; off++) begin
      if (burst_busy) busyCount++;
      if (burst_busy && tone_out && !prevTone) rises++;
      if (burst_done && doneAt == 0) begin
        doneAt = off;
        checkOutput("post_burst_idx", active_idx, 0);
      end
      prevTone = tone_out;
      idle(1);
    end
    checkOutput("burst_busy_len", busyCount, 20);
    checkOutput("burst_done_at", doneAt, 21);
    checkOutput("burst_rises", rises, 2);

    applyStimulus(0, 0, 0, 4'b0001, 1, 2'd2, 28'd5);
    busyCount = burst_busy;
    applyStimulus(0, 0, 0, 4'b0001, 1, 2'd0, 28'd50);
    for (int off = 2; off <= 40; off++) begin
      if (burst_busy) busyCount++;
      idle(1);
    end
    checkOutput("busy_restart_ignored", busyCount, 5);

    applyStimulus(0, 0, 0, 4'b0001, 1, 2'd1, 28'd0);
    checkOutput("len0_done", burst_done, 1);
    checkOutput("len0_busy", burst_busy, 0);
    idle(1);
    checkOutput("len0_done_once", burst_done, 0);

    applyStimulus(1, 2'd0, 20'd0, 4'b0001, 0, 0, 0);
    checkOutput("h0_active", active, 0);
    checkOutput("h0_tone", tone_out, 0);
    applyStimulus(1, 2'd0, 20'd1, 4'b0001, 0, 0, 0);
    checkOutput("h1_tone_a", tone_out, 0);
    idle(1); checkOutput("h1_tone_b", tone_out, 1);
    idle(1); checkOutput("h1_tone_c", tone_out, 0);
    idle(1); checkOutput("h1_tone_d", tone_out, 1);

    applyStimulus(0, 0, 0, 4'b0001, 1, 2'd2, 28'd30);
    idle(5);
    rst = 1'b1;
    idle(1);
    checkOutput("rst_busy", burst_busy, 0);
    checkOutput("rst_done", burst_done, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_tone", tone_out, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 4'b0010, 0, 0, 0);
    checkOutput("rst_no_done", burst_done, 0);
    checkOutput("rst_default_ch1", active_idx, 1);
    applyStimulus(0, 0, 0, 4'b0100, 0, 0, 0);
    checkOutput("rst_ch2_cleared", active, 0);

    for (int i = 0; i < 4; i++)
      applyStimulus(1, 2'(i), 20'($urandom_range(1, 6)), 4'b0000, 0, 0, 0);
    for (int n = 0; n < 20000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      applyStimulus($urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
                    20'($urandom_range(0, 6)),
                    ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : en,
                    $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
                    28'($urandom_range(0, 30)));
    end
    rst = 1'b0;
    checkEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
